// File: rtl/fp_busy_tracker_pkg.sv
// Shared Cop1 definitions: tracker state, datapath widths and per-funct busy times.
// The FP ALU control decoder uses the same busy-time constants, so both blocks stay consistent.
package fp_busy_tracker_pkg;

    localparam int unsigned BtWidth  = 5;
    localparam int unsigned RegWidth = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // Execution latency in cycles for each supported Cop1 arithmetic funct.
    // A value of 0 marks an illegal or unsupported funct.
    localparam logic [BtWidth-1:0] BtAddS    = 5'd6;
    localparam logic [BtWidth-1:0] BtSubS    = 5'd6;
    localparam logic [BtWidth-1:0] BtMulS    = 5'd4;
    localparam logic [BtWidth-1:0] BtDivS    = 5'd5;
    localparam logic [BtWidth-1:0] BtSqrtS   = 5'd15;
    localparam logic [BtWidth-1:0] BtAbsS    = 5'd1;
    localparam logic [BtWidth-1:0] BtMovS    = 5'd1;
    localparam logic [BtWidth-1:0] BtNegS    = 5'd1;
    localparam logic [BtWidth-1:0] BtCmp     = 5'd1;
    localparam logic [BtWidth-1:0] BtIllegal = 5'd0;

endpackage

// File: rtl/fp_busy_tracker.sv
// Tracks the single in-flight Cop1 operation: counts down its latency, stalls issue on
// structural/RAW/CC hazards and emits one-cycle writeback strobes when the result retires.
module fp_busy_tracker
    import fp_busy_tracker_pkg::*;
#(
    parameter int unsigned BT_W  = BtWidth,
    parameter int unsigned REG_W = RegWidth
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iIssue,
    input  logic [BT_W-1:0]  iBusyTime,
    input  logic [REG_W-1:0] iDestReg,
    input  logic             iWritesReg,
    input  logic             iWritesCC,
    input  logic [REG_W-1:0] iSrcA,
    input  logic [REG_W-1:0] iSrcB,
    input  logic             iReadsCC,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oStall,
    output logic             oHazard,
    output logic             oWbEn,
    output logic             oWbCC,
    output logic [REG_W-1:0] oWbReg,
    output logic             oIllegal
);

    logic [BT_W-1:0]  count_q, count_d;
    logic [REG_W-1:0] pend_dest_q, pend_dest_d;
    logic             pend_wr_q, pend_wr_d;
    logic             pend_cc_q, pend_cc_d;
    logic             wb_en_q, wb_en_d;
    logic             wb_cc_q, wb_cc_d;
    logic [REG_W-1:0] wb_reg_q, wb_reg_d;
    logic             illegal_q, illegal_d;

    state_e state;
    logic   busy;
    logic   hazard;
    logic   stall;
    logic   accept;

    assign busy  = (count_q != '0);
    assign state = busy ? StBusy : StIdle;

    assign hazard = busy & ((pend_wr_q & ((iSrcA == pend_dest_q) | (iSrcB == pend_dest_q))) |
                            (pend_cc_q & iReadsCC));

    // A hazard at count 1 still stalls: the register file forwards the result a cycle later.
    assign stall  = iIssue & ((count_q > BT_W'(1)) | hazard);
    assign accept = iIssue & ~stall & ~iFlush;

    always_comb begin
        count_d     = count_q;
        pend_dest_d = pend_dest_q;
        pend_wr_d   = pend_wr_q;
        pend_cc_d   = pend_cc_q;
        wb_en_d     = 1'b0;
        wb_cc_d     = 1'b0;
        wb_reg_d    = '0;
        illegal_d   = 1'b0;

        if (iFlush) begin
            count_d     = '0;
            pend_dest_d = '0;
            pend_wr_d   = 1'b0;
            pend_cc_d   = 1'b0;
        end else begin
            case (state)
                StBusy: begin
                    count_d = count_q - BT_W'(1);
                    if (count_q == BT_W'(1)) begin
                        wb_en_d     = pend_wr_q;
                        wb_cc_d     = pend_cc_q;
                        wb_reg_d    = pend_dest_q;
                        pend_dest_d = '0;
                        pend_wr_d   = 1'b0;
                        pend_cc_d   = 1'b0;
                    end
                end
                default: ;
            endcase

            // A back-to-back accept at count 1 overrides the retiring op's pending state.
            if (accept) begin
                if (iBusyTime != '0) begin
                    count_d     = iBusyTime;
                    pend_dest_d = iDestReg;
                    pend_wr_d   = iWritesReg;
                    pend_cc_d   = iWritesCC;
                end else begin
                    illegal_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_q     <= '0;
            pend_dest_q <= '0;
            pend_wr_q   <= 1'b0;
            pend_cc_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_cc_q     <= 1'b0;
            wb_reg_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            pend_dest_q <= pend_dest_d;
            pend_wr_q   <= pend_wr_d;
            pend_cc_q   <= pend_cc_d;
            wb_en_q     <= wb_en_d;
            wb_cc_q     <= wb_cc_d;
            wb_reg_q    <= wb_reg_d;
            illegal_q   <= illegal_d;
        end
    end

    assign oBusy    = busy;
    assign oStall   = stall;
    assign oHazard  = hazard;
    assign oWbEn    = wb_en_q;
    assign oWbCC    = wb_cc_q;
    assign oWbReg   = wb_reg_q;
    assign oIllegal = illegal_q;

endmodule

// File: doc/fp_busy_tracker.md
# fp_busy_tracker

Multi-cycle FP execution tracker for the Cop1 datapath, sitting directly downstream of the FP ALU control decoder. Takes the decoded busy time (cycles) and destination of each issued FP operation, counts it down, stalls the issue stage on structural and RAW hazards, and emits a one-cycle writeback strobe with the destination register when the result is ready. Only one FP operation is in flight at a time.

## Interface
- BT_W, 5, width of busy-time field / countdown counter (max latency 31)
- REG_W, 5, FP register index width
- iCLK  in  1  clock, rising edge
- iRST  in  1  asynchronous, active-high reset
- iIssue  in  1  issue stage presents a decoded FP op this cycle
- iBusyTime  in  BT_W  latency from the decoder; 0 = illegal/unsupported funct
- iDestReg  in  REG_W  FP destination of issued op
- iWritesReg  in  1  issued op writes an FP register
- iWritesCC  in  1  issued op writes the FP condition flag (c.eq/c.lt/c.le)
- iSrcA, iSrcB  in  REG_W  FP sources of the op in the issue stage
- iReadsCC  in  1  op in issue stage reads the condition flag (bc1t/bc1f)
- iFlush  in  1  synchronous abort of the in-flight op
- oBusy  out  1  an op is in flight (count != 0)
- oStall  out  1  issue stage must hold its instruction this cycle
- oHazard  out  1  RAW/CC hazard against the in-flight op
- oWbEn  out  1  one-cycle register writeback strobe
- oWbCC  out  1  one-cycle condition-flag writeback strobe
- oWbReg  out  REG_W  destination for the writeback, valid while oWbEn
- oIllegal  out  1  one-cycle pulse: issued op had iBusyTime == 0

## Operation
- Reset values: counter 0, all pending/writeback registers 0, every output 0.
- States: IDLE (count 0), BUSY (count >= 1). Writeback strobes are registered side outputs, not a state.
- Accept condition: iIssue & ~oStall & ~iFlush at a rising edge.
- Accept with iBusyTime = N > 0: count <= N; latch iDestReg, iWritesReg, iWritesCC as pending.
- Accept with iBusyTime = 0: counter unchanged (stays 0), oIllegal = 1 next cycle, no writeback ever.
- BUSY: count decrements each edge; the edge taking count 1 -> 0 loads oWbReg <= pending dest, oWbEn <= pending writes-reg, oWbCC <= pending writes-CC.
- Back-to-back: accept is allowed when count <= 1; on that edge the old op retires (strobes load) and the new op loads pending/count in the same edge.
- oHazard (combinational) = oBusy & ((pend writes-reg & (iSrcA == pend dest | iSrcB == pend dest)) | (pend writes-CC & iReadsCC)).
- oStall (combinational) = iIssue & ((count > 1) | oHazard). Hazard at count == 1 still stalls; result is forwarded by register file one cycle later.
- iFlush: count <= 0, pending cleared, no strobe for the flushed op; iFlush wins over a simultaneous accept and over the final 1 -> 0 retire.
- Reset mid-operation: all state cleared asynchronously; no strobe is produced.

## Timing
- Accept at edge E0 with latency N: oBusy high cycles after E0..E(N-1); oWbEn/oWbCC high for exactly one cycle after edge EN.
- N = 1: strobe in the cycle following E1; oBusy high only for cycle after E0.
- oStall, oHazard, oBusy derive from registered state plus same-cycle inputs; no input-to-output path through oWb*.
- oIllegal asserts the cycle after the accepting edge, one cycle wide.

## Structure
- Shared Cop1 package: state enum (IDLE, BUSY), BT_W/REG_W constants, per-funct busy-time constants (shared with the decoder so both stay consistent).
- Single module; no sub-module — counter and hazard compare are small enough inline.

## Test plan
- Reset, then issue ADD.S (N=6, dest f4): oBusy 6 cycles, oWbEn=1 with oWbReg=4 exactly one cycle after 6th edge.
- During DIV.S (N=5, dest f2), present op with iSrcA=f2: oHazard=1, oStall=1 until count 1; unrelated op stalls structurally until count <= 1.
- Back-to-back: MUL.S (N=4, f1) then ABS.S (N=1, f3) issued at count 1: strobe f1, then one cycle later strobe f3; no lost writeback.
- C.LT (N=1, iWritesCC) followed by bc1t (iReadsCC): stall while in flight, oWbCC=1 once, oWbEn=0.
- Issue with iBusyTime=0: oIllegal one-cycle pulse, oBusy stays 0, no strobe.
- SQRT (N=15) then iFlush at count 7, and separately iRST asserted mid-op: counter 0 immediately/next edge, no oWbEn ever, all outputs 0.
